// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MIPS data-port read-modify-write adapter:
//   - state_e     : adapter FSM states
//   - BYTE_FULL   : byteenable pattern for a whole-word store
//   - BYTE_NONE   : byteenable pattern for a store that touches nothing
//   - merge_word  : per-byte merge of new store data into an old RAM word
// ---------------------------------------------------------------------------
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_RESP = 2'd1,
      RMW_WRITE = 2'd2
   } state_e;

   localparam logic [3:0] BYTE_FULL = 4'hF;
   localparam logic [3:0] BYTE_NONE = 4'h0;

   // Byte i of the result comes from new_word when be[i] is set, else from old_word.
   function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mips_byte_merge.sv
// ---------------------------------------------------------------------------
// mips_byte_merge
// Combinational 4-lane byte mux producing the word written back during the
// second cycle of a read-modify-write.
// Ports:
//   old_word_i     : word read from RAM in the first RMW cycle
//   new_word_i     : CPU store data
//   byteenable_i   : lane select, bit i picks new_word_i byte i
//   merged_o       : merged word
// ---------------------------------------------------------------------------
module mips_byte_merge
   import mips_mem_pkg::*;
(
   input  logic [31:0] old_word_i,
   input  logic [31:0] new_word_i,
   input  logic [3:0]  byteenable_i,
   output logic [31:0] merged_o
);

   assign merged_o = merge_word(old_word_i, new_word_i, byteenable_i);

endmodule

// File: rtl/mips_data_port_rmw.sv
// ---------------------------------------------------------------------------
// mips_data_port_rmw
// Adapter between the byte-enabled MIPS data port and a word-wide RAM with
// combinational read and single-cycle write. Loads are registered behind
// waitrequest, whole-word stores pass straight through, and partial stores
// become a two-cycle read-modify-write so the RAM needs no byte enables.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   cpu_address          : byte address (bits [1:0] ignored)
//   cpu_read/cpu_write   : requests; write wins when both are high
//   cpu_byteenable       : store lane enables
//   cpu_writedata        : store data
//   cpu_waitrequest      : high while the request is not yet complete
//   cpu_readdata         : load data, valid when waitrequest drops on a read
//   ram_address          : word-aligned RAM address
//   ram_read/ram_write   : RAM strobes (write commits at posedge)
//   ram_writedata        : word to RAM
//   ram_readdata         : combinational RAM read data
//   rmw_count            : saturating count of completed read-modify-writes
// ---------------------------------------------------------------------------
module mips_data_port_rmw
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [3:0]        cpu_byteenable,
   input  logic [31:0]       cpu_writedata,
   output logic              cpu_waitrequest,
   output logic [31:0]       cpu_readdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_read,
   output logic              ram_write,
   output logic [31:0]       ram_writedata,
   input  logic [31:0]       ram_readdata,
   output logic [CNT_W-1:0]  rmw_count
);

   localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q,  addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         be_q,    be_d;
   logic [31:0]        old_q,   old_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [31:0]        merged_s;

   mips_byte_merge u_merge (
      .old_word_i   (old_q),
      .new_word_i   (wdata_q),
      .byteenable_i (be_q),
      .merged_o     (merged_s)
   );

   assign cpu_readdata = rdata_q;
   assign rmw_count    = cnt_q;

   // Next-state, latch-enable and RAM/CPU handshake decode.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      be_d            = be_q;
      old_d           = old_q;
      rdata_d         = rdata_q;
      cnt_d           = cnt_q;
      cpu_waitrequest = 1'b0;
      ram_read        = 1'b0;
      ram_write       = 1'b0;
      ram_address     = cpu_address & ADDR_MASK;
      ram_writedata   = cpu_writedata;
      if (!reset_n) begin
         // Suppress all RAM strobes while reset is held so an in-flight
         // RMW is abandoned without touching memory.
         cpu_waitrequest = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_write) begin
                  if (cpu_byteenable == BYTE_FULL) begin
                     ram_write = 1'b1;
                  end else if (cpu_byteenable == BYTE_NONE) begin
                     ram_write = 1'b0;
                  end else begin
                     // First RMW cycle: capture the old word and the request.
                     ram_read        = 1'b1;
                     cpu_waitrequest = 1'b1;
                     addr_d          = cpu_address;
                     wdata_d         = cpu_writedata;
                     be_d            = cpu_byteenable;
                     old_d           = ram_readdata;
                     state_d         = RMW_WRITE;
                  end
               end else if (cpu_read) begin
                  ram_read        = 1'b1;
                  cpu_waitrequest = 1'b1;
                  rdata_d         = ram_readdata;
                  state_d         = READ_RESP;
               end else begin
                  state_d = IDLE;
               end
            end
            READ_RESP: begin
               state_d = IDLE;
            end
            RMW_WRITE: begin
               ram_address   = addr_q & ADDR_MASK;
               ram_writedata = merged_s;
               ram_write     = 1'b1;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  cnt_d = cnt_q;
               end
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, request latches, load register and RMW counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= 32'h0000_0000;
         be_q    <= 4'h0;
         old_q   <= 32'h0000_0000;
         rdata_q <= 32'h0000_0000;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         old_q   <= old_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mips_data_port_rmw.sv
// ---------------------------------------------------------------------------
// tb_mips_data_port_rmw
// Directed bench for mips_data_port_rmw. A second instance with a 2-bit
// counter shares the CPU stimulus so counter saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_mips_data_port_rmw;

   logic        clk;
   logic        reset_n;
   logic [31:0] cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [3:0]  cpu_byteenable;
   logic [31:0] cpu_writedata;

   logic        cpu_waitrequest;
   logic [31:0] cpu_readdata;
   logic [31:0] ram_address;
   logic        ram_read;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic [31:0] ram_readdata;
   logic [15:0] rmw_count;

   logic        wait2;
   logic [31:0] rdata2;
   logic [31:0] ram_address2;
   logic        ram_read2;
   logic        ram_write2;
   logic [31:0] ram_writedata2;
   logic [31:0] ram_readdata2;
   logic [1:0]  rmw_count2;

   logic [31:0] ram  [16];
   logic [31:0] ram2 [16];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   mips_data_port_rmw #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cpu_address     (cpu_address),
      .cpu_read        (cpu_read),
      .cpu_write       (cpu_write),
      .cpu_byteenable  (cpu_byteenable),
      .cpu_writedata   (cpu_writedata),
      .cpu_waitrequest (cpu_waitrequest),
      .cpu_readdata    (cpu_readdata),
      .ram_address     (ram_address),
      .ram_read        (ram_read),
      .ram_write       (ram_write),
      .ram_writedata   (ram_writedata),
      .ram_readdata    (ram_readdata),
      .rmw_count       (rmw_count)
   );

   mips_data_port_rmw #(.ADDR_W(32), .CNT_W(2)) dut2 (
      .clk             (clk),
      .reset_n         (reset_n),
      .cpu_address     (cpu_address),
      .cpu_read        (cpu_read),
      .cpu_write       (cpu_write),
      .cpu_byteenable  (cpu_byteenable),
      .cpu_writedata   (cpu_writedata),
      .cpu_waitrequest (wait2),
      .cpu_readdata    (rdata2),
      .ram_address     (ram_address2),
      .ram_read        (ram_read2),
      .ram_write       (ram_write2),
      .ram_writedata   (ram_writedata2),
      .ram_readdata    (ram_readdata2),
      .rmw_count       (rmw_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: combinational read, write committed at posedge.
   assign ram_readdata  = ram[ram_address[5:2]];
   assign ram_readdata2 = ram2[ram_address2[5:2]];

   always @(posedge clk) begin
      if (ram_write)  ram[ram_address[5:2]]   <= ram_writedata;
      if (ram_write2) ram2[ram_address2[5:2]] <= ram_writedata2;
   end

   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
      @(negedge clk);
      cpu_read       = r;
      cpu_write      = w;
      cpu_address    = a;
      cpu_byteenable = be;
      cpu_writedata  = d;
   endtask

   task automatic test_reset;
      reset_n        = 1'b0;
      cpu_read       = 1'b0;
      cpu_write      = 1'b1;
      cpu_address    = 32'h0000_0000;
      cpu_byteenable = 4'hF;
      cpu_writedata  = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk_cnt++; if (ram_write !== 1'b0) $display("FAIL reset_ram_write got %0b want 0", ram_write); else pass_cnt++;
      chk_cnt++; if (ram_read !== 1'b0) $display("FAIL reset_ram_read got %0b want 0", ram_read); else pass_cnt++;
      chk_cnt++; if (cpu_readdata !== 32'h0) $display("FAIL reset_readdata got %h want 0", cpu_readdata); else pass_cnt++;
      chk_cnt++; if (rmw_count !== 16'h0) $display("FAIL reset_count got %h want 0", rmw_count); else pass_cnt++;
      cpu_write = 1'b0;
      reset_n   = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_read;
      drive(1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0);
      #1;
      chk_cnt++; if (cpu_waitrequest !== 1'b1) $display("FAIL read_wait1 got %0b want 1", cpu_waitrequest); else pass_cnt++;
      chk_cnt++; if (ram_read !== 1'b1) $display("FAIL read_ram_read got %0b want 1", ram_read); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (cpu_waitrequest !== 1'b0) $display("FAIL read_wait2 got %0b want 0", cpu_waitrequest); else pass_cnt++;
      chk_cnt++; if (cpu_readdata !== 32'h7856_3412) $display("FAIL read_data got %h want 78563412", cpu_readdata); else pass_cnt++;
      chk_cnt++; if (ram_write !== 1'b0) $display("FAIL read_no_write got %0b want 0", ram_write); else pass_cnt++;
   endtask

   task automatic test_partial_write;
      drive(1'b0, 1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00AA);
      #1;
      chk_cnt++; if (ram_read !== 1'b1 || cpu_waitrequest !== 1'b1 || ram_write !== 1'b0)
         $display("FAIL pw_cycle1 got rd=%0b wait=%0b wr=%0b want 1 1 0", ram_read, cpu_waitrequest, ram_write); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (ram_write !== 1'b1 || cpu_waitrequest !== 1'b0)
         $display("FAIL pw_cycle2 got wr=%0b wait=%0b want 1 0", ram_write, cpu_waitrequest); else pass_cnt++;
      chk_cnt++; if (ram_writedata !== 32'h7856_34AA) $display("FAIL pw_merge got %h want 785634AA", ram_writedata); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (rmw_count !== 16'd1) $display("FAIL pw_count got %0d want 1", rmw_count); else pass_cnt++;
      drive(1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0);
      @(negedge clk); #1;
      chk_cnt++; if (cpu_readdata !== 32'h7856_34AA) $display("FAIL pw_readback got %h want 785634AA", cpu_readdata); else pass_cnt++;
   endtask

   task automatic test_full_write;
      drive(1'b0, 1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF);
      #1;
      chk_cnt++; if (cpu_waitrequest !== 1'b0 || ram_write !== 1'b1 || ram_read !== 1'b0)
         $display("FAIL fw_cycle got wait=%0b wr=%0b rd=%0b want 0 1 0", cpu_waitrequest, ram_write, ram_read); else pass_cnt++;
      chk_cnt++; if (ram_address !== 32'h4 || ram_writedata !== 32'hDEAD_BEEF)
         $display("FAIL fw_bus got %h/%h want 4/DEADBEEF", ram_address, ram_writedata); else pass_cnt++;
      drive(1'b1, 1'b0, 32'h0000_0004, 4'h0, 32'h0);
      @(negedge clk); #1;
      chk_cnt++; if (cpu_readdata !== 32'hDEAD_BEEF) $display("FAIL fw_readback got %h want DEADBEEF", cpu_readdata); else pass_cnt++;
      chk_cnt++; if (rmw_count !== 16'd1) $display("FAIL fw_count got %0d want 1", rmw_count); else pass_cnt++;
   endtask

   task automatic test_read_and_write;
      // Address 0x8 word preloaded to 11223344; unaligned low bits ignored.
      drive(1'b1, 1'b1, 32'h0000_000B, 4'b1100, 32'hCAFE_0000);
      #1;
      chk_cnt++; if (ram_read !== 1'b1 || cpu_waitrequest !== 1'b1)
         $display("FAIL rw_cycle1 got rd=%0b wait=%0b want 1 1", ram_read, cpu_waitrequest); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (ram_write !== 1'b1 || ram_address !== 32'h8 || ram_writedata !== 32'hCAFE_3344)
         $display("FAIL rw_cycle2 got wr=%0b a=%h d=%h want 1 8 CAFE3344", ram_write, ram_address, ram_writedata); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (ram[2] !== 32'hCAFE_3344) $display("FAIL rw_ram got %h want CAFE3344", ram[2]); else pass_cnt++;
      chk_cnt++; if (rmw_count !== 16'd2) $display("FAIL rw_count got %0d want 2", rmw_count); else pass_cnt++;
      chk_cnt++; if (cpu_readdata !== 32'hDEAD_BEEF) $display("FAIL rw_readreg got %h want DEADBEEF", cpu_readdata); else pass_cnt++;
   endtask

   task automatic test_empty_write;
      drive(1'b0, 1'b1, 32'h0000_000C, 4'h0, 32'hFFFF_FFFF);
      #1;
      chk_cnt++; if (cpu_waitrequest !== 1'b0 || ram_write !== 1'b0 || ram_read !== 1'b0)
         $display("FAIL ew_cycle got wait=%0b wr=%0b rd=%0b want 0 0 0", cpu_waitrequest, ram_write, ram_read); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (ram[3] !== 32'h0) $display("FAIL ew_ram got %h want 0", ram[3]); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      drive(1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h0000_0001);
      drive(1'b0, 1'b1, 32'h0000_0010, 4'b0010, 32'h0000_BB00);
      #1;
      chk_cnt++; if (ram_read !== 1'b1 || cpu_waitrequest !== 1'b1)
         $display("FAIL b2b_accept got rd=%0b wait=%0b want 1 1", ram_read, cpu_waitrequest); else pass_cnt++;
      @(negedge clk); #1;
      // Inputs change during RMW_WRITE; the latched request must still win.
      cpu_address    = 32'h0000_0018;
      cpu_byteenable = 4'hF;
      cpu_writedata  = 32'h1234_5678;
      #1;
      chk_cnt++; if (ram_address !== 32'h10 || ram_writedata !== 32'h0000_BB01)
         $display("FAIL b2b_merge got a=%h d=%h want 10 0000BB01", ram_address, ram_writedata); else pass_cnt++;
      drive(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
      #1;
      chk_cnt++; if (cpu_waitrequest !== 1'b1) $display("FAIL b2b_read_wait got %0b want 1", cpu_waitrequest); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (cpu_readdata !== 32'h0000_BB01) $display("FAIL b2b_read got %h want 0000BB01", cpu_readdata); else pass_cnt++;
      chk_cnt++; if (ram[6] !== 32'h0) $display("FAIL b2b_stray got %h want 0", ram[6]); else pass_cnt++;
   endtask

   task automatic test_reset_abort;
      drive(1'b0, 1'b1, 32'h0000_0000, 4'b0001, 32'h0000_0033);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_cnt++; if (ram_write !== 1'b0) $display("FAIL abort_ram_write got %0b want 0", ram_write); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (ram[0] !== 32'h7856_34AA) $display("FAIL abort_ram got %h want 785634AA", ram[0]); else pass_cnt++;
      chk_cnt++; if (rmw_count !== 16'd0) $display("FAIL abort_count got %0d want 0", rmw_count); else pass_cnt++;
      chk_cnt++; if (cpu_readdata !== 32'h0) $display("FAIL abort_readdata got %h want 0", cpu_readdata); else pass_cnt++;
      @(negedge clk);
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      reset_n   = 1'b1;
      #1;
      chk_cnt++; if (cpu_waitrequest !== 1'b0 || ram_write !== 1'b0 || ram_read !== 1'b0)
         $display("FAIL abort_idle got wait=%0b wr=%0b rd=%0b want 0 0 0", cpu_waitrequest, ram_write, ram_read); else pass_cnt++;
   endtask

   task automatic test_saturation;
      logic [1:0]  exp_small;
      logic [15:0] exp_big;
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b1, 32'h0000_0020, 4'b0001, 32'(k));
         @(negedge clk);
         @(posedge clk); #1;
         exp_big   = 16'(k + 1);
         exp_small = (k >= 2) ? 2'd3 : 2'(k + 1);
         chk_cnt++; if (rmw_count2 !== exp_small)
            $display("FAIL sat_small_%0d got %0d want %0d", k, rmw_count2, exp_small); else pass_cnt++;
         chk_cnt++; if (rmw_count !== exp_big)
            $display("FAIL sat_big_%0d got %0d want %0d", k, rmw_count, exp_big); else pass_cnt++;
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ram[i]  = 32'h0;
         ram2[i] = 32'h0;
      end
      ram[0]  = 32'h7856_3412;
      ram2[0] = 32'h7856_3412;
      ram[2]  = 32'h1122_3344;
      ram2[2] = 32'h1122_3344;
      test_reset();
      test_read();
      test_partial_write();
      test_full_write();
      test_read_and_write();
      test_empty_write();
      test_back_to_back();
      test_reset_abort();
      test_saturation();
      @(negedge clk);
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mips_data_port_rmw.md
# mips_data_port_rmw

Data-port adapter between the MIPS core's byte-enabled data interface and the word-wide data RAM, which has combinational read and single-cycle write. It registers read data behind a waitrequest handshake and passes full-word stores straight through. Partial stores are turned into a two-cycle read-modify-write, so the RAM never needs byte enables. It also keeps a saturating count of read-modify-write operations for bench visibility.

## Interface
Parameters:
- ADDR_W, 32, CPU/RAM byte-address width
- CNT_W, 16, width of the RMW statistics counter

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cpu_address  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_read  in  1  read request
- cpu_write  in  1  write request
- cpu_byteenable  in  4  bit i enables writedata[8i+7:8i]
- cpu_writedata  in  32  store data
- cpu_waitrequest  out  1  high: request not yet complete
- cpu_readdata  out  32  load data, valid when read and waitrequest low
- ram_address  out  ADDR_W  address to RAM, bits [1:0] forced 0
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe, committed at posedge
- ram_writedata  out  32  word to RAM
- ram_readdata  in  32  combinational RAM read data
- rmw_count  out  CNT_W  completed RMW count, saturating

## Operation
- FSM states: IDLE, READ_RESP, RMW_WRITE.
- IDLE, cpu_write with byteenable=4'hF: ram_write=1, ram_writedata=cpu_writedata, waitrequest=0. One cycle, stay IDLE.
- IDLE, cpu_write with byteenable=4'h0: no RAM access, waitrequest=0, stay IDLE.
- IDLE, cpu_write with a partial byteenable:
  - ram_read=1, waitrequest=1.
  - Latch address, writedata, byteenable and ram_readdata.
  - Go to RMW_WRITE.
- RMW_WRITE:
  - ram_address comes from the latched address.
  - ram_writedata = merge(latched word, latched data, latched byteenable).
  - ram_write=1, waitrequest=0, rmw_count += 1 unless already all-ones.
  - Go to IDLE.
- IDLE, cpu_read (no write):
  - ram_read=1, waitrequest=1, latch ram_readdata into the readdata register.
  - Go to READ_RESP.
- READ_RESP: waitrequest=0, cpu_readdata = register, RAM idle, go to IDLE.
- cpu_read and cpu_write both high: treated as a write; the read is ignored.
- Request inputs are sampled only in IDLE. Changes to them during RMW_WRITE or READ_RESP have no effect.
- IDLE with no request: waitrequest=0, ram_read=0, ram_write=0.
- Merge rule: byte i = byteenable[i] ? writedata[8i+7:8i] : old[8i+7:8i].

## Timing
- Reset (reset_n=0 at a posedge):
  - state=IDLE, readdata register=0, rmw_count=0, latched registers=0.
  - ram_write=0 and ram_read=0 for the reset cycle.
- Latency:
  - full or empty write: 1 cycle;
  - partial write: 2 cycles;
  - read: 2 cycles, data valid in the second.
- Handshake: a request completes in the cycle where waitrequest=0 at the posedge. The CPU holds the request until then, and a new request is sampled in the following cycle.
- Back-to-back: a request in the cycle after completion is accepted immediately; there are no idle bubbles.
- Reset asserted while in RMW_WRITE or READ_RESP: the operation is aborted, no RAM write occurs, and rmw_count is not incremented.
- RMW atomicity: no other RAM access is issued between the read and the write of one RMW.
- rmw_count holds at 2^CNT_W-1.
- ram_* outputs are combinational from the state and latched registers, with RAM commit at the posedge.

## Structure
- Package mips_mem_pkg:
  - state enum (IDLE, READ_RESP, RMW_WRITE);
  - BYTE_FULL=4'hF and BYTE_NONE=4'h0 constants;
  - merge function (old, new, byteenable).
- Sub-module mips_byte_merge: a combinational 4-lane mux instantiated for ram_writedata in RMW_WRITE.
- The top holds the FSM, latches, readdata register and counter.

## Test plan
- RAM word 0 = 32'h78563412. Read address 0x0 → waitrequest 1 then 0; cpu_readdata = 32'h78563412 in cycle 2; no ram_write.
- Write address 0x0, byteenable 4'b0001, data 32'h000000AA → ram_read in cycle 1, ram_write of 32'h785634AA in cycle 2; rmw_count=1. A subsequent read returns 32'h785634AA.
- Write address 0x4, byteenable 4'hF, data 32'hDEADBEEF → single cycle with waitrequest=0, ram_write=1; read back gives 32'hDEADBEEF; rmw_count unchanged.
- cpu_read and cpu_write both high, address 0x8, byteenable 4'b1100, data 32'hCAFE0000 → handled as an RMW; upper half becomes 16'hCAFE and the lower half is preserved.
- Partial write started, then reset_n=0 in RMW_WRITE → RAM word unchanged, rmw_count=0, state IDLE, readdata=0.
- Force rmw_count to 16'hFFFE, then run 3 partial writes → count reads 16'hFFFF and holds.
